// File: rtl/vreg_file_grouped.sv
// Vector register file with LMUL grouping, byte-masked multi-beat writeback, dual grouped read ports.
// Latency: reads registered (1 cycle); writes commit on accepted beat edge, write-first bypass to reads.
// Backpressure: wb_ready is high whenever out of reset; reads and writes never stall each other.
module vreg_file_grouped #(
    parameter int NREGS     = 32,
    parameter int ELEN      = 32,
    parameter int MAXLMUL   = 8,
    parameter int BEAT_REGS = 2,
    parameter int SELW      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_valid,
    input  logic [SELW-1:0]              rd0_sel,
    input  logic [SELW-1:0]              rd1_sel,
    input  logic [2:0]                   rd_vlmul,
    output logic [MAXLMUL*ELEN-1:0]      rd0_data,
    output logic [MAXLMUL*ELEN-1:0]      rd1_data,
    output logic                         rd_data_valid,
    output logic                         rd_err,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [SELW-1:0]              wb_sel,
    input  logic [2:0]                   wb_vlmul,
    input  logic [BEAT_REGS*ELEN-1:0]    wb_data,
    input  logic [BEAT_REGS*ELEN/8-1:0]  wb_be,
    output logic                         wb_busy,
    output logic                         wb_err
);
    localparam int BEB = ELEN / 8;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [ELEN-1:0]   regs_q [NREGS];
    logic [ELEN-1:0]   regs_d [NREGS];
    logic [SELW-1:0]   base_q, base_d;
    logic [3:0]        grp_q, grp_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wb_err_d;
    logic              wb_acc;
    logic [SELW-1:0]   wbase, widx;
    logic [3:0]        wg, nreg;
    logic [3:0]        rg;
    logic [SELW-1:0]   rb0, rb1;
    logic [MAXLMUL*ELEN-1:0] rd0_nxt, rd1_nxt;
    logic              rd_mis;

    function automatic logic [3:0] grp_size(input logic [2:0] vlmul);
        logic [3:0] g;
        case (vlmul)
            3'd1:    g = 4'd2;
            3'd2:    g = 4'd4;
            3'd3:    g = 4'd8;
            default: g = 4'd1;
        endcase
        if (int'(g) > MAXLMUL) g = 4'(MAXLMUL);
        return g;
    endfunction

    function automatic logic misaligned(input logic [SELW-1:0] sel, input logic [2:0] vlmul);
        logic [SELW-1:0] mask;
        mask = SELW'(grp_size(vlmul)) - SELW'(1);
        return (vlmul == 3'd4) || ((sel & mask) != '0);
    endfunction

    assign wb_ready = reset;
    assign wb_acc   = wb_valid & wb_ready;
    assign wb_busy  = (state_q == BURST);

    // Next register state: the accepted beat is merged here so reads see post-write values.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        grp_d    = grp_q;
        cnt_d    = cnt_q;
        wb_err_d = 1'b0;
        regs_d   = regs_q;
        wbase    = base_q;
        wg       = grp_q;
        nreg     = '0;
        widx     = '0;
        if (wb_acc) begin
            if (state_q == IDLE) begin
                if (misaligned(wb_sel, wb_vlmul)) begin
                    wb_err_d = 1'b1;
                end else begin
                    wg     = grp_size(wb_vlmul);
                    wbase  = wb_sel;
                    base_d = wb_sel;
                    grp_d  = wg;
                    nreg   = (int'(wg) > BEAT_REGS) ? 4'(BEAT_REGS) : wg;
                    if (int'(wg) > BEAT_REGS) begin
                        state_d = BURST;
                        cnt_d   = 4'd1;
                    end
                end
            end else begin
                wbase = base_q + SELW'(int'(cnt_q) * BEAT_REGS);
                nreg  = 4'(BEAT_REGS);
                cnt_d = cnt_q + 4'd1;
                if ((int'(cnt_q) + 1) * BEAT_REGS >= int'(grp_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            for (int j = 0; j < BEAT_REGS; j++) begin
                if (j < int'(nreg)) begin
                    widx = wbase + SELW'(j);
                    for (int b = 0; b < BEB; b++) begin
                        if (wb_be[j*BEB+b])
                            regs_d[widx][b*8 +: 8] = wb_data[(j*BEB+b)*8 +: 8];
                    end
                end
            end
        end
    end

    // Misaligned reads still return the group at the base rounded down to a multiple of G.
    always_comb begin
        rg      = grp_size(rd_vlmul);
        rb0     = rd0_sel & ~(SELW'(rg) - SELW'(1));
        rb1     = rd1_sel & ~(SELW'(rg) - SELW'(1));
        rd_mis  = misaligned(rd0_sel, rd_vlmul) | misaligned(rd1_sel, rd_vlmul);
        rd0_nxt = '0;
        rd1_nxt = '0;
        for (int k = 0; k < MAXLMUL; k++) begin
            if (k < int'(rg)) begin
                rd0_nxt[k*ELEN +: ELEN] = regs_d[rb0 + SELW'(k)];
                rd1_nxt[k*ELEN +: ELEN] = regs_d[rb1 + SELW'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            grp_q         <= 4'd1;
            cnt_q         <= '0;
            wb_err        <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
            rd0_data      <= '0;
            rd1_data      <= '0;
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            grp_q         <= grp_d;
            cnt_q         <= cnt_d;
            wb_err        <= wb_err_d;
            regs_q        <= regs_d;
            rd_data_valid <= rd_valid;
            rd_err        <= rd_valid & rd_mis;
            if (rd_valid) begin
                rd0_data <= rd0_nxt;
                rd1_data <= rd1_nxt;
            end
        end
    end
endmodule

// File: tb/tb_vreg_file_grouped.sv
// Bench for vreg_file_grouped: directed scenarios plus randomized traffic against a
// transaction-level model (register array, pending-beat bookkeeping).
module tb_vreg_file_grouped;
    localparam int NREGS = 32, ELEN = 32, MAXLMUL = 8, BR = 2, SELW = 5;
    localparam int RW = MAXLMUL * ELEN;

    logic clk = 1'b0;
    logic reset;
    logic rd_valid;
    logic [SELW-1:0] rd0_sel, rd1_sel;
    logic [2:0] rd_vlmul;
    logic [RW-1:0] rd0_data, rd1_data;
    logic rd_data_valid, rd_err;
    logic wb_valid, wb_ready;
    logic [SELW-1:0] wb_sel;
    logic [2:0] wb_vlmul;
    logic [BR*ELEN-1:0] wb_data;
    logic [BR*ELEN/8-1:0] wb_be;
    logic wb_busy, wb_err;

    vreg_file_grouped dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd0_sel(rd0_sel), .rd1_sel(rd1_sel),
        .rd_vlmul(rd_vlmul), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd_data_valid(rd_data_valid), .rd_err(rd_err), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_sel(wb_sel), .wb_vlmul(wb_vlmul), .wb_data(wb_data), .wb_be(wb_be),
        .wb_busy(wb_busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Model state
    logic [ELEN-1:0] mem [NREGS];
    int pend_left, p_g, p_next;
    logic [RW-1:0] exp_rd0, exp_rd1;
    logic exp_rdv, exp_rderr, exp_err;
    int vectors = 0, miscompares = 0, checks = 0;

    function automatic int gsize(input logic [2:0] v);
        int g;
        g = (v < 3'd4) ? (1 << v) : 1;
        return (g > MAXLMUL) ? MAXLMUL : g;
    endfunction

    function automatic bit mis(input logic [SELW-1:0] s, input logic [2:0] v);
        return (v == 3'd4) || ((int'(s) % gsize(v)) != 0);
    endfunction

    function automatic logic [RW-1:0] group_of(input logic [SELW-1:0] s, input logic [2:0] v);
        logic [RW-1:0] r;
        int g, b;
        g = gsize(v);
        b = int'(s) - (int'(s) % g);
        r = '0;
        for (int k = 0; k < g; k++) r[k*ELEN +: ELEN] = mem[b+k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_beat();
        int n;
        n = (p_g < BR) ? p_g : BR;
        for (int j = 0; j < n; j++)
            for (int b = 0; b < ELEN/8; b++)
                if (wb_be[j*(ELEN/8)+b]) mem[p_next+j][b*8 +: 8] = wb_data[(j*ELEN/8+b)*8 +: 8];
        p_next += n;
        pend_left--;
    endtask

    // Advance one clock: update model from current inputs, then compare DUT outputs after the edge.
    task automatic step();
        chk("wb_ready", RW'(wb_ready), RW'(reset));
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) mem[r] = '0;
            pend_left = 0;
            exp_rd0 = '0; exp_rd1 = '0; exp_rdv = 0; exp_rderr = 0; exp_err = 0;
        end else begin
            exp_err = 0;
            if (wb_valid) begin
                if (pend_left == 0) begin
                    if (mis(wb_sel, wb_vlmul)) exp_err = 1;
                    else begin
                        p_g = gsize(wb_vlmul);
                        p_next = int'(wb_sel);
                        pend_left = (p_g + BR - 1) / BR;
                        model_beat();
                    end
                end else model_beat();
            end
            exp_rdv = rd_valid;
            exp_rderr = rd_valid && (mis(rd0_sel, rd_vlmul) || mis(rd1_sel, rd_vlmul));
            if (rd_valid) begin
                exp_rd0 = group_of(rd0_sel, rd_vlmul);
                exp_rd1 = group_of(rd1_sel, rd_vlmul);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        chk("rd_data_valid", RW'(rd_data_valid), RW'(exp_rdv));
        if (exp_rdv) chk("rd_err", RW'(rd_err), RW'(exp_rderr));
        chk("rd0_data", rd0_data, exp_rd0);
        chk("rd1_data", rd1_data, exp_rd1);
        chk("wb_busy", RW'(wb_busy), RW'(pend_left > 0));
        chk("wb_err", RW'(wb_err), RW'(exp_err));
    endtask

    task automatic quiet();
        reset = 1; rd_valid = 0; wb_valid = 0;
    endtask

    task automatic wr(input int sel, input int vl, input logic [BR*ELEN-1:0] d, input logic [BR*ELEN/8-1:0] be);
        wb_valid = 1; wb_sel = SELW'(sel); wb_vlmul = 3'(vl); wb_data = d; wb_be = be;
    endtask

    task automatic rd(input int s0, input int s1, input int vl);
        rd_valid = 1; rd0_sel = SELW'(s0); rd1_sel = SELW'(s1); rd_vlmul = 3'(vl);
    endtask

    initial begin
        logic [RW-1:0] lit;
        reset = 0; rd_valid = 0; wb_valid = 0; rd0_sel = 0; rd1_sel = 0; rd_vlmul = 0;
        wb_sel = 0; wb_vlmul = 0; wb_data = 0; wb_be = 0;
        pend_left = 0; p_g = 1; p_next = 0;
        step(); step();
        chk("reset_rd0_lit", rd0_data, '0);

        // Reset clears written registers
        quiet(); wr(3, 0, 64'h0000_0000_DEAD_BEEF, 8'h0F); step();
        quiet(); rd(3, 3, 0); step();
        chk("r3_lit", rd0_data, RW'(32'hDEADBEEF));
        quiet(); reset = 0; step();
        quiet(); rd(3, 3, 0); step();
        chk("r3_after_reset_lit", rd0_data, '0);

        // Single beat, vlmul=1
        quiet(); wr(4, 1, 64'h2222_2222_1111_1111, 8'hFF); step();
        quiet(); rd(4, 4, 1); step();
        chk("pair_lit", rd0_data, RW'(64'h2222_2222_1111_1111));
        chk("pair_rderr_lit", RW'(rd_err), '0);

        // Burst with a bubble after beat 2
        quiet(); wr(8, 3, {32'h9, 32'h8}, 8'hFF); step();
        chk("busy_b1_lit", RW'(wb_busy), RW'(1));
        quiet(); wr(0, 0, {32'hB, 32'hA}, 8'hFF); step();
        quiet(); step();
        chk("busy_bubble_lit", RW'(wb_busy), RW'(1));
        quiet(); wr(0, 0, {32'hD, 32'hC}, 8'hFF); step();
        quiet(); wr(0, 0, {32'hF, 32'hE}, 8'hFF); step();
        chk("busy_end_lit", RW'(wb_busy), '0);
        quiet(); rd(8, 8, 3); step();
        lit = {32'hF, 32'hE, 32'hD, 32'hC, 32'hB, 32'hA, 32'h9, 32'h8};
        chk("burst_lit", rd0_data, lit);

        // Byte mask
        quiet(); wr(0, 0, 64'hAABBCCDD, 8'h0F); step();
        quiet(); wr(0, 0, 64'h11223344, 8'h05); step();
        quiet(); rd(0, 0, 0); step();
        chk("bytemask_lit", rd0_data, RW'(32'hAA22CC44));

        // Misaligned write and read
        quiet(); wr(2, 1, 64'h3333_3333_2222_2222, 8'hFF); step();
        quiet(); wr(6, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); step();
        chk("mis_err_lit", RW'(wb_err), RW'(1));
        chk("mis_busy_lit", RW'(wb_busy), '0);
        quiet(); rd(6, 3, 1); step();
        chk("mis_err_clear_lit", RW'(wb_err), '0);
        chk("mis_rderr_lit", RW'(rd_err), RW'(1));
        chk("mis_r67_lit", rd0_data, '0);
        chk("mis_r23_lit", rd1_data, RW'(64'h3333_3333_2222_2222));

        // Bypass then reset mid-burst
        quiet(); wr(8, 3, {32'h6, 32'h5}, 8'hFF); rd(8, 8, 0); step();
        chk("bypass_lit", rd0_data, RW'(32'h5));
        quiet(); reset = 0; wr(0, 0, {32'h7, 32'h7}, 8'hFF); step();
        quiet(); rd(8, 8, 3); step();
        chk("reset_burst_busy_lit", RW'(wb_busy), '0);
        chk("reset_burst_regs_lit", rd0_data, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int v;
            quiet();
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 6) begin
                v = $urandom_range(0, 7);
                wr($urandom_range(0, NREGS-1), v, {$urandom, $urandom}, 8'($urandom));
                if ($urandom_range(0, 1) == 1) wb_sel = wb_sel & ~SELW'(gsize(3'(v)) - 1);
            end
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom_range(0, 7);
                rd($urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1), v);
                if ($urandom_range(0, 1) == 1) begin
                    rd0_sel = rd0_sel & ~SELW'(gsize(3'(v)) - 1);
                    rd1_sel = rd1_sel & ~SELW'(gsize(3'(v)) - 1);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vreg_file_grouped.md
Name: vreg_file_grouped

Overview:
- Parametrised vector register file with LMUL register grouping, byte-masked multi-beat writeback and registered (1-cycle) dual read ports.
- Successor to the single-cycle, level-triggered register file. Adds a proper clocked write FSM with valid/ready handshake, misalignment detection, and write-first bypass.
- Sits between decode (read selects) and the vector ALU writeback path.

Parameters:
- NREGS, 32, number of architectural registers (power of two, ≥ MAXLMUL).
- ELEN, 32, bits per register.
- MAXLMUL, 8, maximum group size in registers (power of two, ≤ 8).
- BEAT_REGS, 2, registers carried per writeback beat (power of two, ≤ MAXLMUL).
- SELW, 5, select width; equals log2(NREGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- rd_valid  in  1  read request this cycle.
- rd0_sel  in  SELW  base register, operand 0.
- rd1_sel  in  SELW  base register, operand 1.
- rd_vlmul  in  3  read group encoding.
- rd0_data  out  MAXLMUL*ELEN  operand 0 group, register base+k at slice k.
- rd1_data  out  MAXLMUL*ELEN  operand 1 group.
- rd_data_valid  out  1  rd*_data valid (1 cycle after rd_valid).
- rd_err  out  1  misaligned read select, aligned with rd_data_valid.
- wb_valid  in  1  writeback beat valid.
- wb_ready  out  1  beat accepted when wb_valid & wb_ready.
- wb_sel  in  SELW  group base; sampled on first beat only.
- wb_vlmul  in  3  write group encoding; sampled on first beat only.
- wb_data  in  BEAT_REGS*ELEN  beat payload, register j at slice j.
- wb_be  in  BEAT_REGS*ELEN/8  byte enables for wb_data.
- wb_busy  out  1  multi-beat burst in progress.
- wb_err  out  1  one-cycle pulse when a transaction is rejected for misalignment.

Behaviour:
- Group size G from vlmul:
  - 0→1, 1→2, 2→4, 3→8, each clamped to MAXLMUL.
  - 5/6/7 (fractional) → 1.
  - 4 (reserved) → 1 and flagged as an error.
- Misaligned means sel mod G ≠ 0, or vlmul = 4.
- Reset (reset = 0 at a clock edge):
  - All registers cleared to 0.
  - rd0_data/rd1_data = 0; rd_data_valid, rd_err, wb_busy, wb_err = 0.
  - FSM to IDLE; beat counter = 0.
  - wb_ready = 0 while reset is low.
  - A burst in progress is abandoned; registers already written are cleared.
- Read path:
  - Registered output, latency 1.
  - Slices k ≥ G are driven 0.
  - A misaligned read still returns data (base rounded down to a multiple of G) with rd_err = 1.
  - When rd_valid = 0, rd*_data hold their previous value and rd_data_valid = 0.
- Write FSM:
  - IDLE: wb_ready = 1. On an accepted beat:
    - Misaligned: no register write, wb_err = 1 next cycle, stay IDLE.
    - Otherwise latch base and G, and write the beat to registers base+j for j < min(BEAT_REGS, G).
    - If G > BEAT_REGS: go to BURST with beat count 1 and wb_busy = 1. Else stay IDLE.
  - BURST: wb_ready = 1; wb_sel/wb_vlmul are ignored. Each accepted beat n writes registers base + n*BEAT_REGS + j.
    - On the beat where (n+1)*BEAT_REGS ≥ G: go to IDLE, clear wb_busy.
    - If wb_valid = 0, hold state (bubbles allowed).
  - Beats per transaction = ceil(G / BEAT_REGS).
- Byte masking: byte b of register slice j is written only if wb_be[j*ELEN/8 + b] = 1; other bytes are retained.
- Bypass (write-first):
  - A read issued in the same cycle as an accepted beat returns the post-write value for the bytes being written.
  - Concurrent read and write never stall each other.
- Address range: base + G − 1 < NREGS always holds for aligned selects, so no wrap-around.

Test Plan:
- Reset: write r3 = 0xDEADBEEF, then pulse reset = 0 for one cycle → read r3, vlmul = 0 returns 0; wb_ready = 0 during reset and 1 the cycle after.
- Single-beat write with read-back: wb_sel = 4, vlmul = 1, data {0x22222222, 0x11111111}, be all 1 → next-cycle read rd0_sel = 4, vlmul = 1 gives slice0 = 0x11111111, slice1 = 0x22222222, slices 2–7 = 0, rd_err = 0.
- Burst with bubble: wb_sel = 8, vlmul = 3, four beats with one idle cycle after beat 2 → wb_busy high from the cycle after beat 1 through beat 4, low afterwards; r8..r15 hold the beat data in order.
- Byte mask: r0 = 0xAABBCCDD, then write 0x11223344 with be = 4'b0101 → r0 = 0xAA22CC44.
- Misaligned write: wb_sel = 6, vlmul = 2 → wb_err pulses for one cycle, wb_busy stays 0, r6/r7 unchanged. Misaligned read rd1_sel = 3, vlmul = 1 → rd_err = 1 with data from r2/r3.
- Bypass plus reset mid-burst: read r8 in the same cycle that beat 1 writes r8 = 0x5 → rd0 slice0 = 0x5. Asserting reset during beat 2 leaves FSM in IDLE with r8..r15 = 0.
